sigma_rotate_sequencer: RTL and testbench

//  Multi-cycle controller that computes the four SHA-256 sigma functions using one shared
//  N-bit circular-right-shift unit. Sequences three rotate/shift terms through the

---
 rtl/sigma_rotate_sequencer_pkg.sv | 7 +
 rtl/sigma_rotate_sequencer_if.sv | 13 +
 rtl/Shift_circular_right.sv | 8 +
 rtl/sigma_rotate_sequencer.sv | 61 ++++++
 tb/tb_sigma_rotate_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/sigma_rotate_sequencer_pkg.sv
// sigma_rotate_sequencer_pkg: sigma selector/state enums plus the SHA-256 rotate-amount and SHR tables
package sigma_rotate_sequencer_pkg;
  typedef enum logic [1:0] {SIG_BIG0, SIG_BIG1, SIG_SML0, SIG_SML1} sigma_sel_t;
  typedef enum logic [2:0] {IDLE, T0, T1, T2, DONE} seq_state_t;
  localparam int SIGMA_AMT [4][3] = '{'{2, 13, 22}, '{6, 11, 25}, '{7, 18, 3}, '{17, 19, 10}};
  localparam bit SIGMA_IS_SHR [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
endpackage

// File: rtl/sigma_rotate_sequencer_if.sv
// sigma_rotate_sequencer_if: request (in_valid/in_ready/in_x/in_sel) and result (out_valid/out_ready/out_y) handshakes plus busy
interface sigma_rotate_sequencer_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_x;
  logic [1:0]   in_sel;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_y;
  logic         busy;
  modport master (output in_valid, in_x, in_sel, out_ready, input in_ready, out_valid, out_y, busy);
  modport slave  (input in_valid, in_x, in_sel, out_ready, output in_ready, out_valid, out_y, busy);
endinterface

// File: rtl/Shift_circular_right.sv
// Shift_circular_right: s = a rotated right by b (a data in, b amount, s result; b below N)
module Shift_circular_right #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);
  assign s = N'({a, a} >> b);
endmodule

// File: rtl/sigma_rotate_sequencer.sv
// sigma_rotate_sequencer: SHA-256 Sigma0/Sigma1/sigma0/sigma1 via three shared-rotator terms (clk, rst, bus slave)
module sigma_rotate_sequencer
  import sigma_rotate_sequencer_pkg::*;
#(parameter int N = 32) (
  input logic clk,
  input logic rst,
  sigma_rotate_sequencer_if.slave bus
);
  seq_state_t   state;
  sigma_sel_t   sel;
  logic [N-1:0] x, acc, amt, rot, term;
  logic [1:0]   k;
  Shift_circular_right #(.N(N)) u_rotr (.a(x), .b(amt), .s(rot));
  always_comb begin
    k = state == T0 ? 2'd0 : state == T1 ? 2'd1 : 2'd2;
    amt = state inside {T0, T1, T2} ? N'(SIGMA_AMT[sel][k] % N) : '0;
    term = SIGMA_IS_SHR[sel] ? rot & ({N{1'b1}} >> amt) : rot;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= SIG_BIG0;
      x             <= '0;
      acc           <= '0;
      bus.out_y     <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          x            <= bus.in_x;
          sel          <= sigma_sel_t'(bus.in_sel);
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
          state        <= T0;
        end
        T0: begin
          acc   <= rot;
          state <= T1;
        end
        T1: begin
          acc   <= acc ^ rot;
          state <= T2;
        end
        T2: begin
          bus.out_y     <= acc ^ term;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigma_rotate_sequencer.sv
// tb_sigma_rotate_sequencer: directed self-checking bench for sigma_rotate_sequencer
module tb_sigma_rotate_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  sigma_rotate_sequencer_if #(.N(32)) bus ();
  sigma_rotate_sequencer #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_req(input logic [1:0] s, input logic [31:0] xv);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      failures++;
      $display("FAIL in_ready_timeout got=%0b want=1", bus.in_ready);
    end
    bus.in_sel = s;
    bus.in_x = xv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_x = 32'hdeadbeef;
    bus.in_sel = 2'd0;
  endtask
  task automatic wait_result(input string name, input logic [31:0] want);
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL %s_latency got=%0d edges want=4 (counting the accept edge)", name, lat);
    end
    checks++;
    if (bus.out_y !== want) begin
      failures++;
      $display("FAIL %s_value got=%h want=%h", name, bus.out_y, want);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x = 32'hffffffff;
    bus.in_sel = 2'd3;
    bus.out_ready = 1'b0;
    tick();
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_y !== 32'h0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset got rdy=%b vld=%b y=%h busy=%b want rdy=1 vld=0 y=0 busy=0",
               bus.in_ready, bus.out_valid, bus.out_y, bus.busy);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_big_sigma0();
    start_req(2'd0, 32'h6a09e667);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL big0_busy got busy=%b rdy=%b want busy=1 rdy=0", bus.busy, bus.in_ready);
    end
    wait_result("big0", 32'hce20b47e);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic test_big1_small0();
    bus.out_ready = 1'b1;
    start_req(2'd1, 32'h510e527f);
    wait_result("big1", 32'h3587272b);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL big1_release got vld=%b rdy=%b want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    start_req(2'd2, 32'h80000000);
    wait_result("sml0", 32'h11002000);
    tick();
    bus.out_ready = 1'b0;
  endtask
  task automatic test_hold();
    int bad = 0;
    start_req(2'd3, 32'h00000001);
    wait_result("sml1", 32'h0000a000);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_y !== 32'h0000a000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable got %0d bad cycles want 0 (y=%h vld=%b rdy=%b)", bad, bus.out_y, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got vld=%b rdy=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask
  task automatic test_back_to_back();
    int last = -1;
    int results = 0;
    int overlap = 0;
    int badgap = 0;
    int badval = 0;
    bus.in_sel = 2'd2;
    bus.in_x = 32'h00000001;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      tick();
      if (bus.out_valid && bus.in_ready) overlap++;
      if (bus.out_valid) begin
        results++;
        if (bus.out_y !== 32'h02004000) badval++;
        if (last >= 0 && c - last != 5) badgap++;
        last = c;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (results != 5) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=5", results);
    end
    checks++;
    if (badval != 0 || badgap != 0) begin
      failures++;
      $display("FAIL b2b_stream got badval=%0d badgap=%0d want 0 0", badval, badgap);
    end
    checks++;
    if (overlap != 0) begin
      failures++;
      $display("FAIL b2b_ready_in_done got=%0d want=0", overlap);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) bus.out_ready = 1'b1;
      tick();
    end
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset_mid();
    start_req(2'd1, 32'hffff0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got rdy=%b vld=%b busy=%b want 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
    end
    start_req(2'd0, 32'h6a09e667);
    wait_result("after_reset", 32'hce20b47e);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_sel = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_big_sigma0();
    test_big1_small0();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
